// File: rtl/instr_fetch_queue_if.sv
//============================================================================
// Module   : instr_fetch_queue_if
// Desc     : Fetch-stage bundle: instruction-memory req/ack, decode pop
//            handshake and redirect/fault signalling.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

interface instr_fetch_queue_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fault;

    // Fetch unit side
    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc, fault,
        input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );

    // Memory / decode / control side
    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc, fault,
        output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_queue.sv
//============================================================================
// Module   : instr_fetch_queue
// Desc     : Owns the fetch PC, issues word reads over req/ack and buffers
//            {instr, pc} in a small prefetch FIFO popped by decode.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_queue_if.master bus
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_REQ   = 2'd1;
    localparam logic [1:0] c_FAULT = 2'd2;

    // Registered state
    logic [1:0]      r_state;
    logic            r_mem_req;
    logic [31:0]     r_mem_addr;
    logic [31:0]     r_fetch_pc;
    logic            r_drop;
    logic            r_fault;
    logic            r_instr_valid;
    logic [31:0]     r_instr;
    logic [31:0]     r_instr_pc;
    logic [c_CW-1:0] r_count;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_wr_ptr;
    logic [31:0]     r_buf_instr [DEPTH];
    logic [31:0]     r_buf_pc    [DEPTH];

    // Next-state
    logic            w_in_fault;
    logic            w_ack;
    logic            w_pop;
    logic            w_redir;
    logic            w_misaligned;
    logic            w_push;
    logic            w_slot_free;
    logic [c_CW-1:0] w_count_after_pop;
    logic [c_CW-1:0] w_count_next;
    logic [c_PW-1:0] w_rd_ptr_next;
    logic [c_PW-1:0] w_wr_ptr_next;
    logic [31:0]     w_fetch_pc_next;
    logic            w_drop_next;
    logic            w_fault_next;
    logic [1:0]      w_state_next;
    logic            w_mem_req_next;
    logic [31:0]     w_mem_addr_next;
    logic            w_instr_valid_next;
    logic [31:0]     w_instr_next;
    logic [31:0]     w_instr_pc_next;

    always_comb begin
        w_in_fault   = (r_state == c_FAULT);
        w_ack        = r_mem_req & bus.mem_ack;
        w_pop        = r_instr_valid & bus.instr_ready;
        w_redir      = bus.redirect & ~w_in_fault;
        w_misaligned = (bus.redirect_pc[1:0] != 2'b00);
        // Acked data is kept only for a live, non-stale request
        w_push       = w_ack & ~r_drop & ~w_redir & ~w_in_fault;
        w_slot_free  = ~r_mem_req | w_ack;

        w_count_after_pop = r_count - c_CW'(w_pop);
        if (w_redir) begin
            w_count_next  = '0;
            w_rd_ptr_next = '0;
            w_wr_ptr_next = '0;
        end else begin
            w_count_next  = w_count_after_pop + c_CW'(w_push);
            w_rd_ptr_next = r_rd_ptr + c_PW'(w_pop);
            w_wr_ptr_next = r_wr_ptr + c_PW'(w_push);
        end

        if (w_redir & ~w_misaligned) begin
            w_fetch_pc_next = bus.redirect_pc;
        end else if (w_push) begin
            w_fetch_pc_next = r_mem_addr + 32'd4;
        end else begin
            w_fetch_pc_next = r_fetch_pc;
        end

        // An unacked request at redirect time becomes stale until its ack
        if (w_redir & r_mem_req & ~w_ack) begin
            w_drop_next = 1'b1;
        end else if (w_ack) begin
            w_drop_next = 1'b0;
        end else begin
            w_drop_next = r_drop;
        end

        w_fault_next = r_fault | (w_redir & w_misaligned);

        w_state_next    = r_state;
        w_mem_req_next  = r_mem_req;
        w_mem_addr_next = r_mem_addr;
        if (w_in_fault | (w_redir & w_misaligned)) begin
            // Let an outstanding request finish, then stay quiet
            w_state_next   = c_FAULT;
            w_mem_req_next = r_mem_req & ~w_ack;
        end else if (w_slot_free) begin
            if (w_count_next < c_DEPTH_CNT) begin
                w_state_next    = c_REQ;
                w_mem_req_next  = 1'b1;
                w_mem_addr_next = w_fetch_pc_next;
            end else begin
                w_state_next   = c_IDLE;
                w_mem_req_next = 1'b0;
            end
        end

        // Head register tracks the entry that will sit at the read pointer
        w_instr_valid_next = (w_count_next != '0);
        w_instr_next       = r_instr;
        w_instr_pc_next    = r_instr_pc;
        if (w_instr_valid_next) begin
            if (w_push && (w_count_after_pop == '0)) begin
                w_instr_next    = bus.mem_rdata;
                w_instr_pc_next = r_mem_addr;
            end else begin
                w_instr_next    = r_buf_instr[w_rd_ptr_next];
                w_instr_pc_next = r_buf_pc[w_rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= RESET_PC;
            r_fetch_pc    <= RESET_PC;
            r_drop        <= 1'b0;
            r_fault       <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            r_state       <= w_state_next;
            r_mem_req     <= w_mem_req_next;
            r_mem_addr    <= w_mem_addr_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_drop        <= w_drop_next;
            r_fault       <= w_fault_next;
            r_instr_valid <= w_instr_valid_next;
            r_instr       <= w_instr_next;
            r_instr_pc    <= w_instr_pc_next;
            r_count       <= w_count_next;
            r_rd_ptr      <= w_rd_ptr_next;
            r_wr_ptr      <= w_wr_ptr_next;
        end
    end

    // Storage needs no reset: entries are only read once written
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_buf_instr[r_wr_ptr] <= bus.mem_rdata;
            r_buf_pc[r_wr_ptr]    <= r_mem_addr;
        end
    end

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.fault       = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
//============================================================================
// Module   : tb_instr_fetch_queue
// Desc     : Directed and randomized stimulus against a queue-based model
//            of the fetch queue.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_instr_fetch_queue;

    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH       = 2;

    logic clk;
    logic rst;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(
        .RESET_PC (TB_RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: queue of {instr, pc}, next fetch address, outstanding request
    logic [63:0] m_q [$];
    logic [31:0] m_fetch;
    logic [31:0] m_addr;
    bit          m_req;
    bit          m_drop;
    bit          m_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit ack, input bit ready, input bit redir,
                        input logic [31:0] rpc, input bit do_rst);
        logic [31:0] rdata;
        logic [63:0] head;
        bit          acked;
        rdata           = $urandom();
        bus.mem_ack     = ack;
        bus.mem_rdata   = rdata;
        bus.instr_ready = ready;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        rst             = do_rst;
        @(posedge clk);
        if (do_rst) begin
            m_q.delete();
            m_fetch = TB_RESET_PC;
            m_addr  = TB_RESET_PC;
            m_req   = 0;
            m_drop  = 0;
            m_fault = 0;
        end else begin
            acked = m_req && ack;
            if (m_q.size() > 0 && ready) void'(m_q.pop_front());
            if (redir && !m_fault) begin
                m_q.delete();
                if (rpc[1:0] != 2'b00) begin
                    m_fault = 1;
                end else begin
                    m_fetch = rpc;
                    m_drop  = m_req && !acked;
                end
            end else if (acked && !m_drop && !m_fault) begin
                m_q.push_back({rdata, m_addr});
                m_fetch = m_addr + 32'd4;
            end
            if (acked) begin
                m_req  = 0;
                m_drop = 0;
            end
            if (!m_req && !m_fault && m_q.size() < DEPTH) begin
                m_req  = 1;
                m_addr = m_fetch;
            end
        end
        #1;
        check("mem_req", bus.mem_req, m_req);
        if (m_req) check("mem_addr", bus.mem_addr, m_addr);
        check("instr_valid", bus.instr_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            head = m_q[0];
            check("instr", bus.instr, head[63:32]);
            check("instr_pc", bus.instr_pc, head[31:0]);
        end
        check("fault", bus.fault, m_fault);
    endtask

    initial begin
        clk             = 0;
        rst             = 1;
        bus.mem_ack     = 0;
        bus.mem_rdata   = 0;
        bus.instr_ready = 0;
        bus.redirect    = 0;
        bus.redirect_pc = 0;

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 32'hFFFF_FFF8);
        check("rst_valid", bus.instr_valid, 0);
        check("rst_instr", bus.instr, 0);
        check("rst_instr_pc", bus.instr_pc, 0);
        check("rst_fault", bus.fault, 0);

        // Address wrap from the top of memory
        step(0, 1, 0, 0, 0);
        check("wrap_a0", bus.mem_addr, 32'hFFFF_FFF8);
        step(1, 1, 0, 0, 0);
        check("wrap_a1", bus.mem_addr, 32'hFFFF_FFFC);
        check("wrap_pc0", bus.instr_pc, 32'hFFFF_FFF8);
        step(1, 1, 0, 0, 0);
        check("wrap_a2", bus.mem_addr, 32'h0000_0000);
        check("wrap_pc1", bus.instr_pc, 32'hFFFF_FFFC);

        // Streaming from 0 with 1-cycle acks and ready held high
        step(1, 1, 1, 32'h0, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
        check("stream_pc", bus.instr_pc, 32'd28);
        check("stream_addr", bus.mem_addr, 32'd32);

        // Decode stalled: exactly DEPTH words, then fetch resumes at 8
        step(1, 0, 1, 32'h0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        check("full_req", bus.mem_req, 0);
        check("full_pc", bus.instr_pc, 32'h0);
        step(0, 1, 0, 0, 0);
        check("resume_pc", bus.instr_pc, 32'h4);
        check("resume_addr", bus.mem_addr, 32'h8);

        // Redirect while a request waits for its ack
        step(1, 0, 1, 32'h0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h100, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("drop_addr", bus.mem_addr, 32'h100);
        check("drop_valid", bus.instr_valid, 0);
        step(1, 0, 0, 0, 0);
        check("drop_pc", bus.instr_pc, 32'h100);

        // Redirect coinciding with ack and pop
        step(1, 1, 1, 32'h40, 0);
        check("rap_valid", bus.instr_valid, 0);
        check("rap_addr", bus.mem_addr, 32'h40);

        // Randomized traffic with redirects, faults and resets
        for (int i = 0; i < 3000; i++) begin
            bit          rd;
            bit          rs;
            logic [31:0] pc;
            rd = ($urandom_range(0, 19) == 0);
            pc = $urandom() & 32'h0000_0FFC;
            if ($urandom_range(0, 7) == 0) pc = 32'hFFFF_FFF0;
            if ($urandom_range(0, 9) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            rs = (m_fault && $urandom_range(0, 7) == 0) || ($urandom_range(0, 499) == 0);
            step(m_req && ($urandom_range(0, 2) != 0), $urandom_range(0, 3) != 0, rd, pc, rs);
        end

        // Misaligned redirect: sticky fault until reset
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h102, 0);
        check("fault_set", bus.fault, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0);
            check("fault_noreq", bus.mem_req, 0);
        end
        step(1, 1, 1, 32'h200, 0);
        check("fault_held", bus.fault, 1);
        check("fault_noreq2", bus.mem_req, 0);
        step(0, 0, 0, 0, 1);
        check("fault_clr", bus.fault, 0);
        step(0, 0, 0, 0, 0);
        check("restart_req", bus.mem_req, 1);
        check("restart_addr", bus.mem_addr, 32'hFFFF_FFF8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
